// File: rtl/ysyx_23060203_mdu.sv
// ============================================================================
// Module      : ysyx_23060203_mdu
// Description : RV M-extension multiply/divide unit. It uses an iterative
//               shift-add multiplier and a restoring divider, with a
//               valid/ready handshake on both sides.
//               Optional macro YSYX_23060203_MDU_FAST_MUL_EN replaces the
//               iterative multiply with a single combinational multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060203_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    input  logic [2:0]      funct,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] val
);

    localparam int                c_CNT_W   = $clog2(XLEN) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(XLEN);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
    localparam logic [XLEN-1:0]   c_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] c_F_MUL    = 3'd0;
    localparam logic [2:0] c_F_MULH   = 3'd1;
    localparam logic [2:0] c_F_MULHSU = 3'd2;
    localparam logic [2:0] c_F_DIV    = 3'd4;
    localparam logic [2:0] c_F_REM    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_funct;
    logic                r_short;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [2*XLEN-1:0]   r_prod;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_shift;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_divisor;
    logic [XLEN-1:0]     r_val;

    // ---------------- request decode ----------------
    logic            w_accept;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_short;
    logic [XLEN-1:0] w_short_val;

    assign w_accept   = in_valid & in_ready & ~flush;
    assign w_is_div   = funct[2];
    assign w_a_signed = (funct == c_F_MULH) | (funct == c_F_MULHSU) |
                        (funct == c_F_DIV)  | (funct == c_F_REM);
    assign w_b_signed = (funct == c_F_MULH) | (funct == c_F_DIV) | (funct == c_F_REM);
    assign w_a_neg    = w_a_signed & alu_a[XLEN-1];
    assign w_b_neg    = w_b_signed & alu_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -alu_a : alu_a;
    assign w_b_mag    = w_b_neg ? -alu_b : alu_b;
    assign w_div_zero = w_is_div & (alu_b == '0);
    assign w_div_ovf  = ((funct == c_F_DIV) | (funct == c_F_REM)) &
                        (alu_a == c_MIN_NEG) & (alu_b == '1);

`ifdef YSYX_23060203_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_a;
    logic [2*XLEN-1:0] w_fast_b;
    logic [2*XLEN-1:0] w_fast;

    assign w_fast_a = {{XLEN{w_a_signed & alu_a[XLEN-1]}}, alu_a};
    assign w_fast_b = {{XLEN{w_b_signed & alu_b[XLEN-1]}}, alu_b};
    assign w_fast   = w_fast_a * w_fast_b;
`endif

    // Special results are known at accept and only wait for one fixup edge.
    always_comb begin
        w_short     = 1'b0;
        w_short_val = '0;
`ifdef YSYX_23060203_MDU_FAST_MUL_EN
        if (!w_is_div) begin
            w_short     = 1'b1;
            w_short_val = (funct == c_F_MUL) ? w_fast[XLEN-1:0] : w_fast[2*XLEN-1:XLEN];
        end
`endif
        if (w_div_zero) begin
            w_short     = 1'b1;
            w_short_val = funct[1] ? alu_a : '1;
        end else if (w_div_ovf) begin
            w_short     = 1'b1;
            w_short_val = funct[1] ? '0 : alu_a;
        end
    end

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     w_minuend;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_val;

    assign w_minuend  = {r_rem, r_shift[XLEN-1]};
    assign w_ge       = w_minuend >= {1'b0, r_divisor};
    assign w_sub      = w_minuend[XLEN-1:0] - r_divisor;
    assign w_prod_fix = r_neg_q ? -r_prod : r_prod;
    assign w_quot_fix = r_neg_q ? -r_shift : r_shift;
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    always_comb begin
        w_fix_val = '0;
        if (r_short)
            w_fix_val = r_val;
        else if (r_state == S_MUL)
            w_fix_val = (r_funct == c_F_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
        else
            w_fix_val = r_funct[1] ? w_rem_fix : w_quot_fix;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clock) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:        if (w_accept) w_state_nxt = w_is_div ? S_DIV : S_MUL;
            S_MUL, S_DIV:  if (r_cnt == c_LAST) w_state_nxt = S_DONE;
            S_DONE:        if (out_ready) w_state_nxt = S_IDLE;
            default:       w_state_nxt = S_IDLE;
        endcase
        if (flush)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_funct   <= '0;
            r_short   <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_prod    <= '0;
            r_mcand   <= '0;
            r_shift   <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_val     <= '0;
        end else if (flush) begin
            r_cnt   <= '0;
            r_short <= 1'b0;
            r_val   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct   <= funct;
                        r_cnt     <= w_short ? c_LAST : '0;
                        r_short   <= w_short;
                        r_val     <= w_short ? w_short_val : '0;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_prod    <= '0;
                        r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
                        r_shift   <= w_is_div ? w_a_mag : w_b_mag;
                        r_rem     <= '0;
                        r_divisor <= w_b_mag;
                    end
                end
                S_MUL: begin
                    if (r_cnt != c_LAST) begin
                        if (r_shift[0])
                            r_prod <= r_prod + r_mcand;
                        r_mcand <= r_mcand << 1;
                        r_shift <= r_shift >> 1;
                        r_cnt   <= r_cnt + c_ONE;
                    end else begin
                        r_val <= w_fix_val;
                        r_cnt <= '0;
                    end
                end
                S_DIV: begin
                    // r_shift carries the dividend out at the top and the quotient in at the bottom.
                    if (r_cnt != c_LAST) begin
                        r_rem   <= w_ge ? w_sub : w_minuend[XLEN-1:0];
                        r_shift <= {r_shift[XLEN-2:0], w_ge};
                        r_cnt   <= r_cnt + c_ONE;
                    end else begin
                        r_val <= w_fix_val;
                        r_cnt <= '0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_val   <= '0;
                        r_short <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign val       = r_val;

endmodule

`default_nettype wire
